// File: rtl/pipeline_pkg.sv
// Encodings and helpers shared by the fetch, decode and execute stages.
package pipeline_pkg;

  // Forward status from an upstream stage to a downstream stage.
  typedef enum logic [3:0] {
    FWD_NONE      = 4'd0,
    FWD_VALID     = 4'd1,
    FWD_BUS_ERROR = 4'd2,
    FWD_ILLEGAL   = 4'd3
  } fwd_status_e;

  // Backward status from a downstream stage; the spare code 3 behaves as READY.
  typedef enum logic [1:0] {
    BWD_READY = 2'd0,
    BWD_STALL = 2'd1,
    BWD_FLUSH = 2'd2
  } bwd_status_e;

  // RV32I base opcodes.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Immediate layout; IMM_R means the instruction carries no immediate.
  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Contents of the decode output register.
  typedef struct packed {
    fwd_status_e status;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } decode_out_t;

  function automatic logic is_rv32i_opcode(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC: return IMM_U;
      OPC_JAL:            return IMM_J;
      OPC_BRANCH:         return IMM_B;
      OPC_STORE:          return IMM_S;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: return IMM_I;
      default:            return IMM_R;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended from instr[31].
module imm_gen
  import pipeline_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  // Select the immediate layout implied by the opcode.
  always_comb begin
    // NOTE: default first so every path assigns imm_o and no latch is inferred.
    imm_o = '0;
    case (imm_fmt(instr_i[6:0]))
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_inner.sv
// RV32I decode stage: one register slice between fetch and execute, with
// stall/flush handshaking and an early JAL redirect back to fetch.
module decode_stage_inner
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  status_forwards_in,
  input  logic [31:0] instruction_reg_in,
  input  logic [31:0] program_counter_reg_in,
  output logic [1:0]  status_backwards_out,
  output logic [31:0] jump_address_backwards_out,
  output logic [3:0]  status_forwards_out,
  output logic [31:0] instruction_reg_out,
  output logic [31:0] program_counter_reg_out,
  output logic [31:0] immediate_reg_out,
  output logic [4:0]  rs1_addr_out,
  output logic [4:0]  rs2_addr_out,
  output logic [4:0]  rd_addr_out,
  input  logic [1:0]  status_backwards_in,
  input  logic [31:0] jump_address_backwards_in
);

  decode_out_t out_d, out_q;
  logic        redirect_pending_d, redirect_pending_q;
  logic [31:0] jump_target_d, jump_target_q;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic        stall, flush, discard, legal, set_redirect;

  imm_gen u_imm_gen (
    .instr_i (instruction_reg_in),
    .imm_o   (imm)
  );

  assign opcode  = instruction_reg_in[6:0];
  assign stall   = (status_backwards_in == BWD_STALL);
  assign flush   = (status_backwards_in == BWD_FLUSH);
  // The slot after a JAL, and anything arriving under a downstream flush, is dead.
  assign discard = flush || redirect_pending_q;
  assign legal   = (instruction_reg_in[1:0] == 2'b11) && is_rv32i_opcode(opcode);

  assign set_redirect = !stall && !discard && (status_forwards_in == FWD_VALID)
                        && legal && (opcode == OPC_JAL);
  assign redirect_pending_d = set_redirect;
  assign jump_target_d      = set_redirect ? program_counter_reg_in + imm : jump_target_q;

  // Build the next output register contents from the incoming fetch slot.
  always_comb begin
    out_d = '0;
    if (!discard) begin
      out_d.instr = instruction_reg_in;
      out_d.pc    = program_counter_reg_in;
      if (status_forwards_in == FWD_VALID) begin
        if (legal) begin
          out_d.status = FWD_VALID;
          out_d.imm    = imm;
          out_d.rs1    = instruction_reg_in[19:15];
          out_d.rs2    = instruction_reg_in[24:20];
          if (opcode != OPC_STORE && opcode != OPC_BRANCH) begin
            out_d.rd = instruction_reg_in[11:7];
          end
        end else begin
          out_d.status = FWD_ILLEGAL;
        end
      end else if (status_forwards_in == FWD_BUS_ERROR) begin
        out_d.status = FWD_BUS_ERROR;
      end
    end
  end

  // Backward status: downstream flush beats our own redirect, which beats stall.
  always_comb begin
    status_backwards_out       = BWD_READY;
    jump_address_backwards_out = '0;
    if (rst) begin
      if (flush) begin
        status_backwards_out       = BWD_FLUSH;
        jump_address_backwards_out = jump_address_backwards_in;
      end else if (redirect_pending_q) begin
        status_backwards_out       = BWD_FLUSH;
        jump_address_backwards_out = jump_target_q;
      end else if (stall) begin
        status_backwards_out = BWD_STALL;
      end
    end
  end

  // Output register holds under stall; the redirect flag lives one cycle regardless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q              <= '0;
      redirect_pending_q <= 1'b0;
      jump_target_q      <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of order.
      redirect_pending_q <= redirect_pending_d;
      jump_target_q      <= jump_target_d;
      if (!stall) begin
        out_q <= out_d;
      end
    end
  end

  assign status_forwards_out     = out_q.status;
  assign instruction_reg_out     = out_q.instr;
  assign program_counter_reg_out = out_q.pc;
  assign immediate_reg_out       = out_q.imm;
  assign rs1_addr_out            = out_q.rs1;
  assign rs2_addr_out            = out_q.rs2;
  assign rd_addr_out             = out_q.rd;

endmodule

// File: tb/tb_decode_stage_inner.sv
// Scoreboard bench for decode_stage_inner: each driven slot pushes the expected
// register contents; a monitor pops and compares one entry after every edge.
`timescale 1ns/1ps
module tb_decode_stage_inner;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  status_forwards_in = '0;
  logic [31:0] instruction_reg_in = '0;
  logic [31:0] program_counter_reg_in = '0;
  logic [1:0]  status_backwards_in = '0;
  logic [31:0] jump_address_backwards_in = '0;
  logic [1:0]  status_backwards_out;
  logic [31:0] jump_address_backwards_out;
  logic [3:0]  status_forwards_out;
  logic [31:0] instruction_reg_out;
  logic [31:0] program_counter_reg_out;
  logic [31:0] immediate_reg_out;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rd_addr_out;

  always #5 clk = ~clk;

  decode_stage_inner dut (
    .clk                        (clk),
    .rst                        (rst),
    .status_forwards_in         (status_forwards_in),
    .instruction_reg_in         (instruction_reg_in),
    .program_counter_reg_in     (program_counter_reg_in),
    .status_backwards_out       (status_backwards_out),
    .jump_address_backwards_out (jump_address_backwards_out),
    .status_forwards_out        (status_forwards_out),
    .instruction_reg_out        (instruction_reg_out),
    .program_counter_reg_out    (program_counter_reg_out),
    .immediate_reg_out          (immediate_reg_out),
    .rs1_addr_out               (rs1_addr_out),
    .rs2_addr_out               (rs2_addr_out),
    .rd_addr_out                (rd_addr_out),
    .status_backwards_in        (status_backwards_in),
    .jump_address_backwards_in  (jump_address_backwards_in)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  localparam logic [31:0] ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] JAL  = 32'h0100_006F;  // jal x0,16
  localparam logic [31:0] LUI  = 32'h1234_50B7;  // lui x1,0x12345
  localparam logic [31:0] SW   = 32'h0051_2423;  // sw x5,8(x2)
  localparam logic [31:0] BEQ  = 32'hFE20_8EE3;  // beq x1,x2,-4

  // Drive one fetch slot plus the execute-side status on the falling edge.
  task automatic drive(input logic [3:0] fs, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [1:0] bs, input logic [31:0] bj);
    @(negedge clk);
    status_forwards_in        = fs;
    instruction_reg_in        = ins;
    program_counter_reg_in    = pc;
    status_backwards_in       = bs;
    jump_address_backwards_in = bj;
  endtask

  task automatic push(input string name, input logic [3:0] st, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    exp_t e;
    e = '{st: st, ins: ins, pc: pc, imm: imm, rs1: rs1, rs2: rs2, rd: rd};
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Scoreboard monitor: registered outputs settle just after each rising edge.
  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (rst && exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (status_forwards_out !== e.st) begin
        n_fail++; $display("FAIL %s status: got %0d want %0d", nm, status_forwards_out, e.st);
      end
      n_checks++;
      if (instruction_reg_out !== e.ins) begin
        n_fail++; $display("FAIL %s instr: got %h want %h", nm, instruction_reg_out, e.ins);
      end
      n_checks++;
      if (program_counter_reg_out !== e.pc) begin
        n_fail++; $display("FAIL %s pc: got %h want %h", nm, program_counter_reg_out, e.pc);
      end
      n_checks++;
      if (immediate_reg_out !== e.imm) begin
        n_fail++; $display("FAIL %s imm: got %h want %h", nm, immediate_reg_out, e.imm);
      end
      n_checks++;
      if ({rs1_addr_out, rs2_addr_out, rd_addr_out} !== {e.rs1, e.rs2, e.rd}) begin
        n_fail++;
        $display("FAIL %s regs: got rs1=%0d rs2=%0d rd=%0d want rs1=%0d rs2=%0d rd=%0d", nm,
                 rs1_addr_out, rs2_addr_out, rd_addr_out, e.rs1, e.rs2, e.rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    drive(FWD_VALID, ADDI, 32'h100, BWD_FLUSH, 32'h400);
    @(negedge clk); #1;
    n_checks++;
    if ({status_forwards_out, instruction_reg_out, program_counter_reg_out, immediate_reg_out,
         rs1_addr_out, rs2_addr_out, rd_addr_out} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got status=%0d instr=%h pc=%h imm=%h want all zero",
                         status_forwards_out, instruction_reg_out, program_counter_reg_out,
                         immediate_reg_out);
    end
    n_checks++;
    if (status_backwards_out !== 2'd0 || jump_address_backwards_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_bwd: got bwd=%0d jump=%h want 0/0",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_NONE, 32'h0, 32'h0, BWD_READY, 32'h0);
    rst = 1'b1;
    push("reset_release", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_addi();
    drive(FWD_VALID, ADDI, 32'h100, BWD_READY, 32'h0);
    push("addi", FWD_VALID, ADDI, 32'h100, 32'd5, 5'd0, 5'd5, 5'd1);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0 || jump_address_backwards_out !== 32'h0) begin
      n_fail++; $display("FAIL addi_bwd: got bwd=%0d jump=%h want 0/0",
                         status_backwards_out, jump_address_backwards_out);
    end
  endtask

  task automatic test_formats();
    drive(FWD_VALID, SW, 32'h104, BWD_READY, 32'h0);
    push("store", FWD_VALID, SW, 32'h104, 32'd8, 5'd2, 5'd5, 5'd0);
    drive(FWD_VALID, BEQ, 32'h108, BWD_READY, 32'h0);
    push("branch", FWD_VALID, BEQ, 32'h108, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0);
    drive(FWD_VALID, 32'hFFFF_FFFF, 32'h300, BWD_READY, 32'h0);
    push("illegal", FWD_ILLEGAL, 32'hFFFF_FFFF, 32'h300, 32'h0, 5'd0, 5'd0, 5'd0);
    drive(FWD_BUS_ERROR, ADDI, 32'h304, BWD_READY, 32'h0);
    push("bus_error", FWD_BUS_ERROR, ADDI, 32'h304, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_jal();
    drive(FWD_VALID, JAL, 32'h200, BWD_READY, 32'h0);
    push("jal", FWD_VALID, JAL, 32'h200, 32'd16, 5'd0, 5'd16, 5'd0);
    drive(FWD_VALID, ADDI, 32'h204, BWD_READY, 32'h0);
    push("jal_shadow", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd2 || jump_address_backwards_out !== 32'h210) begin
      n_fail++; $display("FAIL jal_redirect: got bwd=%0d jump=%h want 2/00000210",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_NONE, 32'h0, 32'h0, BWD_READY, 32'h0);
    push("jal_after", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0 || jump_address_backwards_out !== 32'h0) begin
      n_fail++; $display("FAIL jal_one_cycle: got bwd=%0d jump=%h want 0/0",
                         status_backwards_out, jump_address_backwards_out);
    end
    // Redirect under a stall: flag still lives exactly one cycle, outputs hold.
    drive(FWD_VALID, JAL, 32'h200, BWD_READY, 32'h0);
    push("jal2", FWD_VALID, JAL, 32'h200, 32'd16, 5'd0, 5'd16, 5'd0);
    drive(FWD_VALID, ADDI, 32'h204, BWD_STALL, 32'h0);
    push("jal2_stall", FWD_VALID, JAL, 32'h200, 32'd16, 5'd0, 5'd16, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd2 || jump_address_backwards_out !== 32'h210) begin
      n_fail++; $display("FAIL jal_over_stall: got bwd=%0d jump=%h want 2/00000210",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_NONE, 32'h0, 32'h0, BWD_READY, 32'h0);
    push("jal2_after", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0) begin
      n_fail++; $display("FAIL jal_stall_clear: got bwd=%0d want 0", status_backwards_out);
    end
  endtask

  task automatic test_flush_override();
    drive(FWD_VALID, JAL, 32'h200, BWD_FLUSH, 32'h400);
    push("flush_jal_in", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd2 || jump_address_backwards_out !== 32'h400) begin
      n_fail++; $display("FAIL flush_pass: got bwd=%0d jump=%h want 2/00000400",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_NONE, 32'h0, 32'h0, BWD_READY, 32'h0);
    push("flush_after", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0 || jump_address_backwards_out !== 32'h0) begin
      n_fail++; $display("FAIL flush_no_redirect: got bwd=%0d jump=%h want 0/0",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_VALID, JAL, 32'h200, BWD_READY, 32'h0);
    push("jal3", FWD_VALID, JAL, 32'h200, 32'd16, 5'd0, 5'd16, 5'd0);
    drive(FWD_VALID, ADDI, 32'h204, BWD_FLUSH, 32'h400);
    push("flush_over_jal", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd2 || jump_address_backwards_out !== 32'h400) begin
      n_fail++; $display("FAIL flush_priority: got bwd=%0d jump=%h want 2/00000400",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_NONE, 32'h0, 32'h0, BWD_READY, 32'h0);
    push("flush_over_after", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0) begin
      n_fail++; $display("FAIL flush_cleared: got bwd=%0d want 0", status_backwards_out);
    end
  endtask

  task automatic test_stall();
    drive(FWD_VALID, ADDI, 32'h100, BWD_READY, 32'h0);
    push("pre_stall", FWD_VALID, ADDI, 32'h100, 32'd5, 5'd0, 5'd5, 5'd1);
    for (int i = 0; i < 3; i++) begin
      drive(FWD_VALID, LUI, 32'h104, BWD_STALL, 32'h0);
      push("stall_hold", FWD_VALID, ADDI, 32'h100, 32'd5, 5'd0, 5'd5, 5'd1);
      #1; n_checks++;
      if (status_backwards_out !== 2'd1 || jump_address_backwards_out !== 32'h0) begin
        n_fail++; $display("FAIL stall_bwd[%0d]: got bwd=%0d jump=%h want 1/0", i,
                           status_backwards_out, jump_address_backwards_out);
      end
    end
    drive(FWD_VALID, LUI, 32'h104, BWD_READY, 32'h0);
    push("stall_resume", FWD_VALID, LUI, 32'h104, 32'h1234_5000, 5'd8, 5'd3, 5'd1);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0) begin
      n_fail++; $display("FAIL resume_bwd: got bwd=%0d want 0", status_backwards_out);
    end
  endtask

  task automatic test_reset_mid_redirect();
    drive(FWD_VALID, JAL, 32'h200, BWD_READY, 32'h0);
    push("jal_pre_reset", FWD_VALID, JAL, 32'h200, 32'd16, 5'd0, 5'd16, 5'd0);
    drive(FWD_VALID, ADDI, 32'h204, BWD_FLUSH, 32'h400);
    rst = 1'b0;
    #1; n_checks++;
    if ({status_forwards_out, instruction_reg_out, program_counter_reg_out, immediate_reg_out,
         rs1_addr_out, rs2_addr_out, rd_addr_out} !== '0) begin
      n_fail++; $display("FAIL mid_reset_regs: got status=%0d instr=%h pc=%h imm=%h want all zero",
                         status_forwards_out, instruction_reg_out, program_counter_reg_out,
                         immediate_reg_out);
    end
    n_checks++;
    if (status_backwards_out !== 2'd0 || jump_address_backwards_out !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_bwd: got bwd=%0d jump=%h want 0/0",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_NONE, 32'h0, 32'h0, BWD_READY, 32'h0);
    rst = 1'b1;
    push("post_reset", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0 || jump_address_backwards_out !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_no_flush: got bwd=%0d jump=%h want 0/0",
                         status_backwards_out, jump_address_backwards_out);
    end
    drive(FWD_NONE, 32'h0, 32'h0, BWD_READY, 32'h0);
    push("post_reset2", FWD_NONE, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1; n_checks++;
    if (status_backwards_out !== 2'd0) begin
      n_fail++; $display("FAIL post_reset_no_flush2: got bwd=%0d want 0", status_backwards_out);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_jal();
    test_flush_override();
    test_stall();
    test_reset_mid_redirect();
    @(posedge clk); #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
